// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_DEPTH  = 16;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  // Pointer/level width: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module sync_fifo_ram #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage write and registered read; read data holds when rd_en is low.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, level counter, flag decode and registered read.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter  int DATA_W    = DEFAULT_DATA_W,
  parameter  int DEPTH     = DEFAULT_DEPTH,
  parameter  int AFULL_TH  = 12,
  parameter  int AEMPTY_TH = 2,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int PTR_W     = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
`ifdef SYNC_FIFO_ERR_EN
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr,
`endif
  output logic [ADDR_W:0]   level
);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  level_q, level_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_seen_q, rd_seen_d;
  logic              wr_acc_s, rd_acc_s;
  logic              full_s, empty_s;
  logic [DATA_W-1:0] ram_rd_data_s;

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_acc_s),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (ram_rd_data_s)
  );

  // Flags come only from the registered level; accepts use those flags.
  always_comb begin
    full_s       = (level_q == PTR_W'(DEPTH));
    empty_s      = (level_q == {PTR_W{1'b0}});
    wr_acc_s     = wr_en & ~full_s;
    rd_acc_s     = rd_en & ~empty_s;
    wr_ptr_d     = wr_acc_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = rd_acc_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    rd_valid_d   = rd_acc_s;
    rd_seen_d    = rd_seen_q | rd_acc_s;
    level_d      = level_q;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_d = level_q + PTR_W'(1);
      2'b01:   level_d = level_q - PTR_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state; storage itself is never reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      level_q    <= {PTR_W{1'b0}};
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

  // The RAM output register has no reset, so read data is zero until a read lands after reset.
  assign rd_data      = rd_seen_q ? ram_rd_data_s : {DATA_W{1'b0}};
  assign rd_valid     = rd_valid_q;
  assign level        = level_q;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (level_q >= PTR_W'(AFULL_TH));
  assign almost_empty = (level_q <= PTR_W'(AEMPTY_TH));

`ifdef SYNC_FIFO_ERR_EN
  err_flags_t err_q, err_d;

  // Sticky error flags; a new error in the same cycle wins over err_clr.
  always_comb begin
    err_d.overflow  = (wr_en & full_s)  | (err_q.overflow  & ~err_clr);
    err_d.underflow = (rd_en & empty_s) | (err_q.underflow & ~err_clr);
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= err_flags_t'(2'b00);
    end else begin
      err_q <= err_d;
    end
  end

  assign overflow  = err_q.overflow;
  assign underflow = err_q.underflow;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int DATA_W    = 16;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 12;
  localparam int AEMPTY_TH = 2;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en, rd_en, err_clr;
  logic [DATA_W-1:0] wr_data;
  logic              full, almost_full, empty, almost_empty, rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [LW-1:0]     level;
  logic              overflow, underflow;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] exp_data;
  logic              exp_valid;
  logic              ovf_m, udf_m;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
`ifdef SYNC_FIFO_ERR_EN
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr),
`endif
    .level        (level)
  );

`ifndef SYNC_FIFO_ERR_EN
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  // Drive one cycle of requests and advance the reference model across the edge.
  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
    bit full_m, empty_m;
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; err_clr = c;
    @(posedge clk);
    full_m  = (mq.size() == DEPTH);
    empty_m = (mq.size() == 0);
    ovf_m   = (w && full_m)  || (ovf_m && !c);
    udf_m   = (r && empty_m) || (udf_m && !c);
    if (r && !empty_m) begin
      exp_data  = mq.pop_front();
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    if (w && !full_m) mq.push_back(d);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    ovf_m     = 1'b0;
    udf_m     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_cnt++; if (level !== LW'(0) || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0)
      $display("FAIL reset_flags: level=%0d e=%b ae=%b f=%b af=%b, want 0 1 1 0 0", level, empty, almost_empty, full, almost_full);
    else pass_cnt++;
    chk_cnt++; if (rd_valid !== 1'b0 || rd_data !== '0) $display("FAIL reset_rd: valid=%b data=%h, want 0 0", rd_valid, rd_data);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(16'h5A00 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk_cnt++; if (level !== LW'(4) || rd_data !== DATA_W'(16'h5A00)) $display("FAIL pre_reset: level=%0d data=%h, want 4 5a00", level, rd_data);
    else pass_cnt++;
    step(1'b1, DATA_W'(16'h5A05), 1'b1, 1'b0);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (level !== LW'(0) || empty !== 1'b1 || rd_valid !== 1'b0)
      $display("FAIL async_reset: level=%0d empty=%b valid=%b, want 0 1 0", level, empty, rd_valid);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b0, '0, 1'b1, 1'b0);
    chk_cnt++; if (rd_valid !== 1'b0 || rd_data !== '0 || level !== LW'(0))
      $display("FAIL post_reset_read: valid=%b data=%h level=%0d, want 0 0 0", rd_valid, rd_data, level);
    else pass_cnt++;
    step(1'b1, DATA_W'(16'hABCD), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk_cnt++; if (rd_valid !== 1'b1 || rd_data !== DATA_W'(16'hABCD))
      $display("FAIL post_reset_data: valid=%b data=%h, want 1 abcd", rd_valid, rd_data);
    else pass_cnt++;
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b1, DATA_W'(i), 1'b0, 1'b0);
      chk_cnt++; if (level !== LW'(mq.size()) || full !== (mq.size() == DEPTH))
        $display("FAIL fill_%0d: level=%0d full=%b, want %0d %b", i, level, full, mq.size(), mq.size() == DEPTH);
      else pass_cnt++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk_cnt++; if (rd_valid !== 1'b1 || rd_data !== DATA_W'(i))
        $display("FAIL drain_%0d: valid=%b data=%h, want 1 %h", i, rd_valid, rd_data, DATA_W'(i));
      else pass_cnt++;
    end
    step(1'b0, '0, 1'b0, 1'b0);
    chk_cnt++; if (empty !== 1'b1 || rd_valid !== 1'b0) $display("FAIL drained_empty: empty=%b valid=%b, want 1 0", empty, rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int counts[4] = '{10, 10, 16, 16};
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < counts[ph]; i++) begin
        if (ph % 2 == 0) begin
          step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        end else begin
          step(1'b0, '0, 1'b1, 1'b0);
          chk_cnt++; if (rd_valid !== exp_valid || rd_data !== exp_data)
            $display("FAIL wrap_rd_%0d_%0d: valid=%b data=%h, want %b %h", ph, i, rd_valid, rd_data, exp_valid, exp_data);
          else pass_cnt++;
        end
      end
      chk_cnt++; if (level !== LW'((ph % 2 == 0) ? counts[ph] : 0))
        $display("FAIL wrap_level_%0d: level=%0d, want %0d", ph, level, (ph % 2 == 0) ? counts[ph] : 0);
      else pass_cnt++;
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(16'h1000 + i), 1'b0, 1'b0);
    step(1'b1, DATA_W'(16'hDEAD), 1'b1, 1'b0);
    chk_cnt++; if (level !== LW'(DEPTH - 1) || rd_data !== DATA_W'(16'h1000) || rd_valid !== 1'b1)
      $display("FAIL simul_full: level=%0d data=%h valid=%b, want %0d 1000 1", level, rd_data, rd_valid, DEPTH - 1);
    else pass_cnt++;
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk_cnt++; if (rd_data !== exp_data) $display("FAIL simul_drain_%0d: data=%h, want %h", i, rd_data, exp_data);
      else pass_cnt++;
    end
    step(1'b1, DATA_W'(16'hBEEF), 1'b1, 1'b0);
    chk_cnt++; if (level !== LW'(1) || rd_valid !== 1'b0) $display("FAIL simul_empty: level=%0d valid=%b, want 1 0", level, rd_valid);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) step(1'b1, DATA_W'(16'h2000 + i), 1'b0, 1'b0);
    step(1'b1, DATA_W'(16'h2006), 1'b1, 1'b0);
    chk_cnt++; if (level !== LW'(7) || rd_data !== DATA_W'(16'hBEEF) || rd_valid !== 1'b1)
      $display("FAIL simul_mid: level=%0d data=%h valid=%b, want 7 beef 1", level, rd_data, rd_valid);
    else pass_cnt++;
    while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_thresholds();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, DATA_W'(i), 1'b0, 1'b0);
      chk_cnt++; if (almost_full !== (i >= AFULL_TH) || almost_empty !== (i <= AEMPTY_TH))
        $display("FAIL thresh_up_%0d: af=%b ae=%b, want %b %b", i, almost_full, almost_empty, i >= AFULL_TH, i <= AEMPTY_TH);
      else pass_cnt++;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk_cnt++; if (almost_full !== (i >= AFULL_TH) || almost_empty !== (i <= AEMPTY_TH))
        $display("FAIL thresh_dn_%0d: af=%b ae=%b, want %b %b", i, almost_full, almost_empty, i >= AFULL_TH, i <= AEMPTY_TH);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int wr_pct;
    for (int n = 0; n < 400; n++) begin
      wr_pct = ((n / 50) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < wr_pct, DATA_W'($urandom), $urandom_range(0, 99) >= wr_pct, 1'b0);
      chk_cnt++;
      if (level !== LW'(mq.size()) || rd_valid !== exp_valid || rd_data !== exp_data ||
          full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) ||
          almost_full !== (mq.size() >= AFULL_TH) || almost_empty !== (mq.size() <= AEMPTY_TH))
        $display("FAIL random_%0d: level=%0d valid=%b data=%h f=%b e=%b af=%b ae=%b, want level=%0d valid=%b data=%h",
                 n, level, rd_valid, rd_data, full, empty, almost_full, almost_empty, mq.size(), exp_valid, exp_data);
      else pass_cnt++;
    end
    while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

`ifdef SYNC_FIFO_ERR_EN
  task automatic test_errors();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_quiet: overflow=%b, want 0", overflow);
    else pass_cnt++;
    step(1'b1, DATA_W'(16'hFFFF), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk_cnt++; if (overflow !== ovf_m || overflow !== 1'b1) $display("FAIL ovf_hold: overflow=%b, want 1", overflow);
    else pass_cnt++;
    while (mq.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk_cnt++; if (underflow !== udf_m || underflow !== 1'b1) $display("FAIL udf_set: underflow=%b, want 1", underflow);
    else pass_cnt++;
    step(1'b0, '0, 1'b1, 1'b1);
    chk_cnt++; if (underflow !== 1'b1 || overflow !== 1'b0) $display("FAIL set_wins: udf=%b ovf=%b, want 1 0", underflow, overflow);
    else pass_cnt++;
    step(1'b0, '0, 1'b0, 1'b1);
    chk_cnt++; if (underflow !== 1'b0 || overflow !== 1'b0) $display("FAIL err_clr: udf=%b ovf=%b, want 0 0", underflow, overflow);
    else pass_cnt++;
    step(1'b0, '0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_thresholds();
    test_random();
`ifdef SYNC_FIFO_ERR_EN
    test_errors();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
